// File: rtl/mic_i2s_rx.sv
// mic_i2s_rx: four-line I2S microphone receiver with a
// synchronising front end, word assembler and output FIFO.
module mic_i2s_rx #(
  parameter int SAMPLE_BITS = 24,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        aud_bclk,
  input  logic        aud_adclrck,
  input  logic [3:0]  gpio_din,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow,
  output logic        frame_err,
  input  logic        clr_flags
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(SAMPLE_BITS + 2);
  localparam logic [CW-1:0] C_LAST = CW'(SAMPLE_BITS + 1);

  typedef enum logic [1:0] {SYNC, RUN, PUSH} state_t;

  logic [1:0] r_rst;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst <= '0;
    else          r_rst <= {r_rst[0], 1'b1};
  end
  assign w_rst_n = r_rst[1];

  logic [2:0] r_bclk, r_lrck;
  logic [3:0] r_din0, r_din1;
  logic [1:0] r_warm;
  logic       w_rise, w_ledge;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_bclk <= '0;
      r_lrck <= '0;
      r_din0 <= '0;
      r_din1 <= '0;
      r_warm <= '0;
    end else begin
      r_bclk <= {r_bclk[1:0], aud_bclk};
      r_lrck <= {r_lrck[1:0], aud_adclrck};
      r_din0 <= gpio_din;
      r_din1 <= r_din0;
      if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
    end
  end

  // Hide the spurious edge seen while the cleared pipeline refills.
  assign w_rise  = (r_warm == 2'd3) && r_bclk[1] && !r_bclk[2];
  assign w_ledge = (r_warm == 2'd3) && (r_lrck[1] ^ r_lrck[2]);

  state_t                 r_state, w_nxt;
  logic [CW-1:0]          r_cnt;
  logic [SAMPLE_BITS-1:0] r_sr   [4];
  logic [SAMPLE_BITS-1:0] r_hold [4];
  logic                   r_hlr;
  logic [1:0]             r_pidx;
  logic                   r_ovf, r_ferr;
  logic [AW:0]            r_wp, r_rp;
  logic [31:0]            r_mem [FIFO_DEPTH];

  logic w_wr, w_close, w_ferr_set, w_pdrop;
  logic w_full, w_empty, w_pop, w_push;
  logic [SAMPLE_BITS-1:0] w_sel;
  logic [23:0]            w_samp;
  logic [31:0]            w_word;

  always_comb begin
    w_nxt      = r_state;
    w_wr       = 1'b0;
    w_close    = 1'b0;
    w_ferr_set = 1'b0;
    w_pdrop    = 1'b0;
    unique case (r_state)
      SYNC: if (w_ledge) w_nxt = RUN;
      RUN: begin
        if (w_ledge) begin
          if (r_cnt == C_LAST) begin
            w_close = 1'b1;
            w_nxt   = PUSH;
          end else begin
            w_ferr_set = 1'b1;
          end
        end
      end
      PUSH: begin
        if (w_ledge) begin
          w_pdrop = 1'b1;
          w_nxt   = RUN;
        end else begin
          w_wr = 1'b1;
          if (r_pidx == 2'd3) w_nxt = RUN;
        end
      end
      default: w_nxt = SYNC;
    endcase
    if (!enable) begin
      w_nxt      = SYNC;
      w_wr       = 1'b0;
      w_close    = 1'b0;
      w_ferr_set = 1'b0;
      w_pdrop    = 1'b0;
    end
  end

  assign w_sel = r_hold[r_pidx];

  generate
    if (SAMPLE_BITS >= 24) begin : g_wide
      assign w_samp = w_sel[SAMPLE_BITS-1 -: 24];
    end else begin : g_narrow
      assign w_samp = {w_sel, {(24-SAMPLE_BITS){1'b0}}};
    end
  endgenerate

  assign w_word  = {5'b0, r_pidx, r_hlr, w_samp};
  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW] != r_rp[AW]) &&
                   (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop   = !w_empty && out_ready;
  assign w_push  = w_wr && (!w_full || w_pop);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= SYNC;
      r_cnt   <= '0;
      r_hlr   <= 1'b0;
      r_pidx  <= '0;
      r_ovf   <= 1'b0;
      r_ferr  <= 1'b0;
      r_wp    <= '0;
      r_rp    <= '0;
      for (int i = 0; i < 4; i++) begin
        r_sr[i]   <= '0;
        r_hold[i] <= '0;
      end
    end else begin
      r_state <= w_nxt;
      // A coincident bclk rise is slot 0 of the new word.
      if (w_ledge)
        r_cnt <= w_rise ? CW'(1) : '0;
      else if (w_rise && r_state != SYNC && r_cnt != C_LAST)
        r_cnt <= r_cnt + CW'(1);
      if (w_rise && !w_ledge && r_state != SYNC &&
          r_cnt != '0 && r_cnt != C_LAST) begin
        for (int i = 0; i < 4; i++)
          r_sr[i] <= {r_sr[i][SAMPLE_BITS-2:0], r_din1[i]};
      end
      if (w_close) begin
        for (int i = 0; i < 4; i++) r_hold[i] <= r_sr[i];
        r_hlr <= r_lrck[2];
      end
      r_pidx <= w_wr ? r_pidx + 2'd1 : 2'd0;
      if (w_push) r_wp <= r_wp + (AW+1)'(1);
      if (w_pop)  r_rp <= r_rp + (AW+1)'(1);
      r_ovf  <= w_pdrop || (w_wr && !w_push) ||
                (r_ovf && !clr_flags);
      r_ferr <= w_ferr_set || (r_ferr && !clr_flags);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= w_word;
  end

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? 32'h0 : r_mem[r_rp[AW-1:0]];
  assign overflow  = r_ovf;
  assign frame_err = r_ferr;
endmodule

// File: tb/tb_mic_i2s_rx.sv
// tb_mic_i2s_rx: randomized I2S stimulus with a word-level
// reference model feeding a scoreboard queue.
module tb_mic_i2s_rx;
  localparam int SB    = 24;
  localparam int DEPTH = 16;
  localparam int H     = 40;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        aud_bclk = 1'b0;
  logic        aud_adclrck = 1'b0;
  logic [3:0]  gpio_din = 4'h0;
  logic        out_ready = 1'b0;
  logic        clr_flags = 1'b0;
  logic [31:0] out_data;
  logic        out_valid, overflow, frame_err;

  int total = 0;
  int bad = 0;
  int pops = 0;
  logic [31:0] exp_q[$];
  logic        cur_lr = 1'b0;
  bit          armed = 1'b0;
  bit          pend_ok = 1'b0;
  logic        pend_lr = 1'b0;
  logic [23:0] pend_s [4];
  bit          exp_ovf = 1'b0;
  bit          exp_ferr = 1'b0;

  always #5 clk = ~clk;

  mic_i2s_rx #(.SAMPLE_BITS(SB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .aud_bclk(aud_bclk), .aud_adclrck(aud_adclrck),
    .gpio_din(gpio_din), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .frame_err(frame_err),
    .clr_flags(clr_flags)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got %h want none", out_data);
      end else begin
        chk("word", out_data, exp_q.pop_front());
      end
      pops++;
    end
  end

  task automatic push_exp(logic [31:0] w);
    if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
    else exp_q.push_back(w);
  endtask

  // An lrck edge closes whatever word was in flight.
  task automatic model_edge(logic lr, logic [23:0] smp [4], int ns);
    if (armed && pend_ok) begin
      for (int i = 0; i < 4; i++)
        push_exp({5'b0, 2'(i), pend_lr, pend_s[i]});
    end else if (armed) begin
      exp_ferr = 1'b1;
    end
    armed   = 1'b1;
    pend_lr = lr;
    pend_s  = smp;
    pend_ok = (ns >= SB + 1);
  endtask

  task automatic pulse_reset(int pre);
    #pre;
    reset_n = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", out_data, 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_ferr", 32'(frame_err), 0);
    exp_q.delete();
    armed = 1'b0;
    pend_ok = 1'b0;
    exp_ovf = 1'b0;
    exp_ferr = 1'b0;
    #2;
    reset_n = 1'b1;
    #(H - pre - 3);
  endtask

  task automatic send_word(logic [23:0] smp [4], int ns,
                           bit co, int rst_slot, int pre);
    logic lr;
    lr = ~cur_lr;
    cur_lr = lr;
    for (int s = 0; s < ns; s++) begin
      for (int i = 0; i < 4; i++)
        gpio_din[i] = (s >= 1 && s <= SB) ? smp[i][SB-s]
                                          : 1'($urandom);
      if (s == 0 && !co) begin
        aud_adclrck = lr;
        model_edge(lr, smp, ns);
      end
      if (s == rst_slot) pulse_reset(pre);
      else #H;
      aud_bclk = 1'b1;
      if (s == 0 && co) begin
        aud_adclrck = lr;
        model_edge(lr, smp, ns);
      end
      #H;
      aud_bclk = 1'b0;
    end
  endtask

  task automatic send_rand(int ns, bit co, int rst_slot, int pre);
    logic [23:0] smp [4];
    for (int i = 0; i < 4; i++) smp[i] = 24'($urandom);
    send_word(smp, ns, co, rst_slot, pre);
  endtask

  task automatic chk_flags(string tag);
    chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, "_ferr"}, 32'(frame_err), 32'(exp_ferr));
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    clr_flags = 1'b1;
    @(posedge clk); #1;
    clr_flags = 1'b0;
    exp_ovf = 1'b0;
    exp_ferr = 1'b0;
    #20;
  endtask

  task automatic wait_drain(string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk({tag, "_left"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    logic [23:0] smp [4];
    int p0;
    #2;
    chk("rst0_valid", 32'(out_valid), 0);
    chk("rst0_data", out_data, 0);
    chk("rst0_ovf", 32'(overflow), 0);
    chk("rst0_ferr", 32'(frame_err), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    enable = 1'b1;
    out_ready = 1'b1;
    #100;

    send_rand(32, 0, -1, 0);
    for (int i = 0; i < 4; i++) smp[i] = 24'hA5A5A5;
    send_word(smp, 32, 0, -1, 0);
    for (int i = 0; i < 4; i++) smp[i] = 24'($urandom);
    smp[3] = 24'h123456;
    send_word(smp, 32, 0, -1, 0);
    for (int k = 0; k < 6; k++) send_rand(32, 0, -1, 0);
    chk_flags("run");

    send_rand(10, 0, -1, 0);
    send_rand(32, 0, -1, 0);
    chk_flags("short");
    pulse_clr();
    chk_flags("short_clr");

    send_rand(32, 1, -1, 0);
    send_rand(32, 0, -1, 0);
    send_rand(32, 1, -1, 0);
    send_rand(32, 0, -1, 0);
    wait_drain("coin");

    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) send_rand(32, 0, -1, 0);
    #200;
    chk_flags("full");
    chk("full_head", out_data, exp_q[0]);
    p0 = pops;
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("full");
    #50;
    chk("full_pops", 32'(pops - p0), DEPTH);
    chk("full_empty", 32'(out_valid), 0);
    pulse_clr();
    chk_flags("full_clr");

    send_rand(32, 0, 12, 15);
    for (int k = 0; k < 3; k++) send_rand(32, 0, -1, 0);
    send_rand(32, 0, 0, 33);
    for (int k = 0; k < 4; k++) send_rand(32, 0, -1, 0);
    send_rand(32, 0, -1, 0);
    wait_drain("end");
    chk_flags("end");
    #50;
    chk("end_empty", 32'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
